timer_capture: RTL and testbench
================================

Name: timer_capture

Overview:
- Input-capture unit for the timer subsystem.
- Synchronises an external level input, detects the selected edges, and timestamps each edge with a free-running counter.
- Timestamps are queued in a small FIFO that a host drains through a read handshake.
- Consumes pulses produced elsewhere in the timer design; it is the measuring side of the same path.

Parameters:
- CNT_W, 16, width of free-running counter and timestamps.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- SYNC_STAGES, 2, synchroniser flops on cap_in; >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- clr_b  input  1  reset; synchronous, active-low.
- en  input  1  1 = counter runs and captures are enabled.
- cap_in  input  1  asynchronous capture input.
- edge_sel  input  2  00 none, 01 rising, 10 falling, 11 both.
- rd_en  input  1  pop request for the FIFO head.
- rd_data  output  CNT_W  timestamp at FIFO head (show-ahead).
- rd_edge  output  1  edge type at head: 1 = rising, 0 = falling.
- rd_valid  output  1  equals ~empty.
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.
- count  output  CNT_W  live counter value.
- overflow  output  1  sticky flag: an edge was lost.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (clr_b=0 at a clk edge): the following all go to 0:
  - counter, sync chain, edge-history flop, FIFO pointers and occupancy, overflow.
  - Outputs after reset: empty=1, full=0, rd_valid=0, rd_data=0, rd_edge=0, count=0.
- Reset has priority over every other input. Reset mid-operation discards all queued entries.
- Counter:
  - count <= count+1 when en=1; holds when en=0.
  - Wraps from 2^CNT_W-1 to 0 silently, with no flag.
- Synchroniser and edge detection:
  - cap_in passes through SYNC_STAGES flops; the last stage is s. A history flop p <= s every cycle, regardless of en.
  - rise = s & ~p; fall = ~s & p.
  - hit = en & ((rise & edge_sel[0]) | (fall & edge_sel[1])).
- Latency: with SYNC_STAGES=2, a cap_in transition first sampled at edge k is pushed at edge k+2. At edge k+2, empty falls and rd_data becomes valid.
- Timestamp: the pushed value is count as held during the detection cycle, i.e. the value before edge k+2's increment. rd_edge = rise.
- Reset-release corner: the sync chain resets to 0. If cap_in is held high through reset release, a rising edge is detected SYNC_STAGES cycles later. This is intended; no suppression.
- FIFO:
  - Push on hit when not full, or when full and a pop occurs in the same cycle.
  - Pop on rd_en when not empty. rd_en while empty is ignored.
  - Empty with hit and rd_en together: push only; the pop is ignored.
  - Full with hit and rd_en together: both occur; occupancy unchanged; no overflow.
  - Full with hit and no pop: the edge is dropped and overflow <= 1. Queued data is unchanged.
- Pointers: read and write pointers wrap modulo DEPTH. full and empty are derived from an occupancy counter of width log2(DEPTH)+1.
- Read side:
  - rd_data and rd_edge show the head combinationally from storage.
  - After a pop they show the next entry on the following cycle.
  - When empty they hold the last-read slot's contents; these values are don't-care to consumers.
- overflow:
  - Cleared by ovf_clr=1.
  - If an overflow event and ovf_clr occur in the same cycle, set wins (overflow stays 1).
- Changing edge_sel mid-run takes effect on the next detection cycle. It does not affect queued entries.
- en=0: the counter freezes and no pushes occur, but the synchroniser and p keep tracking. Re-enabling therefore does not create a spurious edge from a level change that happened while disabled.

Test Plan:
- Reset/idle: hold clr_b=0 for 3 cycles, release with en=1 and cap_in=0 → empty=1, full=0, overflow=0, and count=1,2,3 on successive edges.
- Rising capture, edge_sel=01, en=1:
  - Raise cap_in just after the edge where count becomes 10 → entry pushed with rd_data=12, rd_edge=1.
  - Lowering cap_in pushes nothing.
- Both edges, edge_sel=11: pulse cap_in high for 5 cycles → two entries, with rise timestamp T and fall timestamp T+5.
  - Pop with rd_en → rd_edge=1 then 0, then empty=1.
  - Extra rd_en while empty leaves state unchanged.
- Overflow, DEPTH=4:
  - Generate 5 rising edges without reads → full=1 after the 4th edge, overflow=1 after the 5th; the first 4 timestamps are intact.
  - ovf_clr=1 → overflow=0.
  - Same-cycle ovf_clr and drop → overflow stays 1.
- Full with simultaneous push and pop: FIFO full, edge detected in the same cycle as rd_en=1 → oldest entry removed, new one appended, full stays 1, overflow=0.
- Wrap and disable:
  - CNT_W=4, count reaches 15 then 0; an edge captured at wrap gives rd_data=0.
  - With en=0, toggle cap_in → no entries, count frozen.
  - Re-assert en with cap_in steady → no spurious entry.
  - clr_b=0 with 3 entries queued → empty=1 next cycle.

Source files
------------

// File: rtl/timer_capture.sv
// -----------------------------------------------------------------------------
// timer_capture
//
// Input-capture unit for the timer subsystem. An asynchronous level input is
// synchronised, the selected edges are detected, and each detected edge is
// timestamped with a free-running counter. Timestamps (plus the edge type) are
// queued in a small show-ahead FIFO that the host drains with rd_en.
//
// Parameters:
//   CNT_W       - width of the free-running counter and of each timestamp
//   DEPTH       - FIFO entries (power of two, >= 2)
//   SYNC_STAGES - synchroniser flops on cap_in (>= 2)
//
// Ports:
//   clk      in   single clock, all state changes on the rising edge
//   clr_b    in   synchronous active-low reset, highest priority
//   en       in   1 = counter runs and captures are enabled
//   cap_in   in   asynchronous capture input
//   edge_sel in   00 none, 01 rising, 10 falling, 11 both
//   rd_en    in   pop request for the FIFO head
//   rd_data  out  timestamp at the FIFO head (show-ahead)
//   rd_edge  out  edge type at the head: 1 = rising, 0 = falling
//   rd_valid out  head is valid (~empty)
//   empty    out  FIFO empty
//   full     out  FIFO full
//   count    out  live counter value
//   overflow out  sticky: an edge was lost because the FIFO was full
//   ovf_clr  in   clears overflow (a same-cycle loss keeps it set)
// -----------------------------------------------------------------------------
module timer_capture #(
  parameter int CNT_W       = 16,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clr_b,
  input  logic             en,
  input  logic             cap_in,
  input  logic [1:0]       edge_sel,
  input  logic             rd_en,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_edge,
  output logic             rd_valid,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that "DEPTH entries" is distinguishable from zero.
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Free-running counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // Wraps silently through 2^CNT_W-1 -> 0.
  always_comb begin
    count_next = count_reg;
    if (en) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_b) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   s;
  logic                   p_reg;
  logic                   rise;
  logic                   fall;
  logic                   hit;

  // Shift cap_in in at bit 0; the oldest stage is the synchronised level.
  assign sync_next = {sync_reg[SYNC_STAGES-2:0], cap_in};
  assign s         = sync_reg[SYNC_STAGES-1];

  // The history flop tracks s even while disabled, so a level change made
  // while en=0 never shows up as an edge once en is raised again.
  always_ff @(posedge clk) begin
    if (!clr_b) begin
      sync_reg <= '0;
      p_reg    <= 1'b0;
    end else begin
      sync_reg <= sync_next;
      p_reg    <= s;
    end
  end

  assign rise = s & ~p_reg;
  assign fall = ~s & p_reg;
  assign hit  = en & ((rise & edge_sel[0]) | (fall & edge_sel[1]));

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_next;
  logic             pop;
  logic             push;
  logic             drop;

  assign empty    = (occ_reg == '0);
  assign full     = (occ_reg == OCC_FULL);
  assign rd_valid = ~empty;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts an
  // edge when the host reads concurrently. A pop on an empty FIFO is ignored
  // even if a push lands in that cycle.
  assign pop  = rd_en & ~empty;
  assign push = hit & (~full | pop);
  assign drop = hit & full & ~pop;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_next = occ_reg + OCC_W'(1);
      2'b01:   occ_next = occ_reg - OCC_W'(1);
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_b) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // Slots are cleared by reset so the head reads as zero straight after
  // reset. The head is read combinationally (show-ahead).
  logic [CNT_W-1:0] slot_ts   [DEPTH];
  logic             slot_edge [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [CNT_W-1:0] ts_reg;
      logic             edge_reg;

      // Timestamp is the counter value held during the detection cycle,
      // i.e. before this edge's increment.
      always_ff @(posedge clk) begin
        if (!clr_b) begin
          ts_reg   <= '0;
          edge_reg <= 1'b0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          ts_reg   <= count_reg;
          edge_reg <= rise;
        end
      end

      assign slot_ts[gi]   = ts_reg;
      assign slot_edge[gi] = edge_reg;
    end
  endgenerate

  assign rd_data = slot_ts[rd_ptr_reg];
  assign rd_edge = slot_edge[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Sticky overflow
  // ---------------------------------------------------------------------------
  logic overflow_reg;
  logic overflow_next;

  // A loss in the same cycle as a clear wins, so no lost edge goes unreported.
  always_comb begin
    overflow_next = overflow_reg;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_b) begin
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= overflow_next;
    end
  end

  assign overflow = overflow_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_timer_capture.sv
// -----------------------------------------------------------------------------
// tb_timer_capture
//
// Directed bench for timer_capture. The main instance uses the default
// 16-bit counter; a second instance with a 4-bit counter covers wrap-around.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_timer_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (CNT_W = 16)
  logic        clr_b, en, cap_in, rd_en, ovf_clr;
  logic [1:0]  edge_sel;
  logic [15:0] rd_data, count;
  logic        rd_edge, rd_valid, empty, full, overflow;

  // Narrow instance (CNT_W = 4)
  logic        w_clr_b, w_en, w_cap_in, w_rd_en, w_ovf_clr;
  logic [1:0]  w_edge_sel;
  logic [3:0]  w_rd_data, w_count;
  logic        w_rd_edge, w_rd_valid, w_empty, w_full, w_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  timer_capture #(.CNT_W(16), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .clr_b(clr_b), .en(en), .cap_in(cap_in), .edge_sel(edge_sel),
    .rd_en(rd_en), .rd_data(rd_data), .rd_edge(rd_edge), .rd_valid(rd_valid),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  timer_capture #(.CNT_W(4), .DEPTH(4), .SYNC_STAGES(2)) dut_w (
    .clk(clk), .clr_b(w_clr_b), .en(w_en), .cap_in(w_cap_in),
    .edge_sel(w_edge_sel), .rd_en(w_rd_en), .rd_data(w_rd_data),
    .rd_edge(w_rd_edge), .rd_valid(w_rd_valid), .empty(w_empty),
    .full(w_full), .count(w_count), .overflow(w_overflow),
    .ovf_clr(w_ovf_clr)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Two reset cycles, then release; count reads 0 on return.
  task automatic do_reset(input logic lvl, input logic [1:0] sel);
    clr_b = 1'b0; en = 1'b1; cap_in = lvl; rd_en = 1'b0; ovf_clr = 1'b0;
    edge_sel = sel;
    tick(2);
    clr_b = 1'b1;
  endtask

  task automatic pop_one();
    $display("pop: ts=%0d edge=%0b", rd_data, rd_edge);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  // Raise for 2 cycles, low for 2: a rise raised at count c is stamped c+2.
  task automatic rise_pulse();
    cap_in = 1'b1;
    tick(2);
    cap_in = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    clr_b = 1'b0; en = 1'b1; cap_in = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    edge_sel = 2'b01;
    tick(3);
    clr_b = 1'b1;
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %0b want 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %0b want 0", full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", overflow); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", rd_valid); else n_pass++;
    n_checks++; if (rd_data !== 16'd0 || rd_edge !== 1'b0) $display("FAIL reset_head: got %0d/%0b want 0/0", rd_data, rd_edge); else n_pass++;
    n_checks++; if (count !== 16'd0) $display("FAIL reset_count0: got %0d want 0", count); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      n_checks++; if (count !== 16'(i)) $display("FAIL reset_count_run: got %0d want %0d", count, i); else n_pass++;
    end
    $display("reset: done");
  endtask

  task automatic test_rising();
    do_reset(1'b0, 2'b01);
    tick(10);                       // count = 10
    cap_in = 1'b1;
    tick(2);
    n_checks++; if (empty !== 1'b1) $display("FAIL rise_latency: got empty=%0b want 1", empty); else n_pass++;
    tick(1);
    n_checks++; if (empty !== 1'b0 || rd_valid !== 1'b1) $display("FAIL rise_push: got empty=%0b valid=%0b want 0/1", empty, rd_valid); else n_pass++;
    n_checks++; if (rd_data !== 16'd12 || rd_edge !== 1'b1) $display("FAIL rise_ts: got %0d/%0b want 12/1", rd_data, rd_edge); else n_pass++;
    cap_in = 1'b0;
    tick(4);
    pop_one();
    n_checks++; if (empty !== 1'b1) $display("FAIL rise_fall_ignored: got empty=%0b want 1", empty); else n_pass++;
  endtask

  task automatic test_reset_release();
    do_reset(1'b1, 2'b01);          // cap_in held high through release
    tick(2);
    n_checks++; if (empty !== 1'b1) $display("FAIL rel_latency: got empty=%0b want 1", empty); else n_pass++;
    tick(1);
    n_checks++; if (empty !== 1'b0 || rd_data !== 16'd2 || rd_edge !== 1'b1) $display("FAIL rel_rise: got e=%0b %0d/%0b want 0 2/1", empty, rd_data, rd_edge); else n_pass++;
  endtask

  task automatic test_both_edges();
    do_reset(1'b0, 2'b11);
    tick(5);                        // count = 5
    cap_in = 1'b1;
    tick(5);                        // count = 10
    cap_in = 1'b0;
    tick(3);                        // count = 13, both entries queued
    n_checks++; if (rd_data !== 16'd7 || rd_edge !== 1'b1) $display("FAIL both_rise: got %0d/%0b want 7/1", rd_data, rd_edge); else n_pass++;
    pop_one();
    n_checks++; if (rd_data !== 16'd12 || rd_edge !== 1'b0 || empty !== 1'b0) $display("FAIL both_fall: got %0d/%0b e=%0b want 12/0 e=0", rd_data, rd_edge, empty); else n_pass++;
    pop_one();
    n_checks++; if (empty !== 1'b1) $display("FAIL both_drained: got empty=%0b want 1", empty); else n_pass++;
    rd_en = 1'b1; tick(1); rd_en = 1'b0;   // pop while empty, count = 16
    n_checks++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) $display("FAIL empty_pop: got e=%0b f=%0b o=%0b want 1/0/0", empty, full, overflow); else n_pass++;
    // Empty with push and rd_en together: the push survives.
    cap_in = 1'b1;
    tick(2);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;   // push of ts 18
    n_checks++; if (empty !== 1'b0 || rd_data !== 16'd18 || rd_edge !== 1'b1) $display("FAIL empty_push_pop: got e=%0b %0d/%0b want 0 18/1", empty, rd_data, rd_edge); else n_pass++;
    pop_one();
    n_checks++; if (empty !== 1'b1) $display("FAIL empty_push_pop_occ: got empty=%0b want 1", empty); else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset(1'b0, 2'b01);
    for (int i = 0; i < 4; i++) rise_pulse();   // ts 2,6,10,14; count = 16
    n_checks++; if (full !== 1'b1 || overflow !== 1'b0) $display("FAIL ovf_fill: got f=%0b o=%0b want 1/0", full, overflow); else n_pass++;
    rise_pulse();                               // 5th edge dropped; count = 20
    n_checks++; if (full !== 1'b1 || overflow !== 1'b1) $display("FAIL ovf_set: got f=%0b o=%0b want 1/1", full, overflow); else n_pass++;
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;    // count = 21
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clr: got %0b want 0", overflow); else n_pass++;
    cap_in = 1'b1;
    tick(2);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;    // drop and clear together
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins: got %0b want 1", overflow); else n_pass++;
    cap_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rd_data !== 16'(2 + 4 * i) || rd_edge !== 1'b1) $display("FAIL ovf_data%0d: got %0d/%0b want %0d/1", i, rd_data, rd_edge, 2 + 4 * i); else n_pass++;
      pop_one();
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL ovf_drained: got empty=%0b want 1", empty); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0, 2'b01);
    for (int i = 0; i < 4; i++) rise_pulse();   // full with 2,6,10,14
    cap_in = 1'b1;
    tick(2);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;        // push ts 18 + pop 2
    n_checks++; if (full !== 1'b1 || overflow !== 1'b0 || rd_data !== 16'd6) $display("FAIL b2b_full: got f=%0b o=%0b head=%0d want 1/0/6", full, overflow, rd_data); else n_pass++;
    cap_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rd_data !== 16'(6 + 4 * i)) $display("FAIL b2b_data%0d: got %0d want %0d", i, rd_data, 6 + 4 * i); else n_pass++;
      pop_one();
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL b2b_drained: got empty=%0b want 1", empty); else n_pass++;
  endtask

  task automatic test_wrap();
    w_clr_b = 1'b0; w_en = 1'b1; w_cap_in = 1'b0; w_rd_en = 1'b0;
    w_ovf_clr = 1'b0; w_edge_sel = 2'b01;
    tick(2);
    w_clr_b = 1'b1;
    tick(14);
    n_checks++; if (w_count !== 4'd14) $display("FAIL wrap_14: got %0d want 14", w_count); else n_pass++;
    w_cap_in = 1'b1;
    tick(1);
    n_checks++; if (w_count !== 4'd15) $display("FAIL wrap_15: got %0d want 15", w_count); else n_pass++;
    tick(1);
    n_checks++; if (w_count !== 4'd0 || w_overflow !== 1'b0) $display("FAIL wrap_0: got %0d o=%0b want 0/0", w_count, w_overflow); else n_pass++;
    tick(1);
    n_checks++; if (w_empty !== 1'b0 || w_rd_data !== 4'd0 || w_rd_edge !== 1'b1 || w_count !== 4'd1) $display("FAIL wrap_ts: got e=%0b %0d/%0b cnt=%0d want 0 0/1 1", w_empty, w_rd_data, w_rd_edge, w_count); else n_pass++;
    $display("wrap: ts=%0d", w_rd_data);
  endtask

  task automatic test_disable_and_reset();
    do_reset(1'b0, 2'b11);
    tick(3);                        // count = 3
    en = 1'b0;
    cap_in = 1'b1; tick(3);
    cap_in = 1'b0; tick(3);
    cap_in = 1'b1; tick(4);
    n_checks++; if (empty !== 1'b1 || count !== 16'd3) $display("FAIL dis_frozen: got e=%0b cnt=%0d want 1/3", empty, count); else n_pass++;
    en = 1'b1;                      // cap_in steady high
    tick(4);                        // count = 7
    n_checks++; if (empty !== 1'b1 || count !== 16'd7) $display("FAIL dis_reenable: got e=%0b cnt=%0d want 1/7", empty, count); else n_pass++;
    cap_in = 1'b0; tick(3);         // fall, ts 9
    cap_in = 1'b1; tick(3);         // rise, ts 12
    cap_in = 1'b0; tick(3);         // fall, ts 15
    n_checks++; if (empty !== 1'b0 || full !== 1'b0 || rd_data !== 16'd9 || rd_edge !== 1'b0) $display("FAIL three_q: got e=%0b f=%0b %0d/%0b want 0/0 9/0", empty, full, rd_data, rd_edge); else n_pass++;
    clr_b = 1'b0;
    tick(1);
    n_checks++; if (empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 || count !== 16'd0) $display("FAIL mid_reset: got e=%0b f=%0b v=%0b cnt=%0d want 1/0/0/0", empty, full, rd_valid, count); else n_pass++;
    clr_b = 1'b1;
  endtask

  initial begin
    w_clr_b = 1'b0; w_en = 1'b0; w_cap_in = 1'b0; w_rd_en = 1'b0;
    w_ovf_clr = 1'b0; w_edge_sel = 2'b00;
    test_reset();
    test_rising();
    test_reset_release();
    test_both_edges();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_disable_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
